// File: rtl/rotation_finder_pkg.sv
// Shared types and helpers for the rotation finder and its companion rotator.
package rotation_finder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } rf_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int unsigned RF_MAX_WIDTH = 64;

    // Rotate the low `width` bits of `word` left by one; bits above `width` are zeroed.
    function automatic logic [RF_MAX_WIDTH-1:0] rotl1(
        input logic [RF_MAX_WIDTH-1:0] word,
        input int unsigned             width
    );
        logic [RF_MAX_WIDTH-1:0] mask;
        mask = (RF_MAX_WIDTH'(1) << width) - RF_MAX_WIDTH'(1);
        return ((word << 1) | (word >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/rotation_finder.sv
// Searches one left-rotation step per clock for the rotation mapping orig onto rotated,
// and reports it in the rotator's dir/shift_amt encoding.
module rotation_finder
    import rotation_finder_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] orig,
    input  logic [WIDTH-1:0] rotated,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             found,
    output logic             dir,
    output logic [AW-1:0]    shift_amt
);

    rf_state_t        state_q, state_d;
    logic [WIDTH-1:0] cand_q, tgt_q;
    logic [AW-1:0]    k_q;

    logic             start_ready_d, done_valid_d;
    logic             found_d, dir_d;
    logic [AW-1:0]    shift_amt_d;
    logic             enc_dir;
    logic [AW-1:0]    enc_amt;

    logic match, last;
    assign match = (cand_q == tgt_q);
    assign last  = (k_q == AW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid)   state_d = SEARCH;
            SEARCH:  if (match || last) state_d = DONE;
            DONE:    if (done_ready)    state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; the result is latched only when the search ends.
    always_comb begin
        start_ready_d = (state_d == IDLE);
        done_valid_d  = (state_d == DONE);
        found_d       = found;
        dir_d         = dir;
        shift_amt_d   = shift_amt;

        enc_dir = DIR_LEFT;
        enc_amt = k_q;
        if (k_q > AW'(WIDTH / 2)) begin
            enc_dir = DIR_RIGHT;
            // WIDTH truncates to zero in AW bits, so this yields WIDTH - k.
            enc_amt = AW'(WIDTH) - k_q;
        end

        if (state_q == SEARCH) begin
            if (match) begin
                found_d     = 1'b1;
                dir_d       = enc_dir;
                shift_amt_d = enc_amt;
            end else if (last) begin
                found_d     = 1'b0;
                dir_d       = DIR_LEFT;
                shift_amt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_ready <= 1'b1;
            done_valid  <= 1'b0;
            found       <= 1'b0;
            dir         <= 1'b0;
            shift_amt   <= '0;
            cand_q      <= '0;
            tgt_q       <= '0;
            k_q         <= '0;
        end else begin
            start_ready <= start_ready_d;
            done_valid  <= done_valid_d;
            found       <= found_d;
            dir         <= dir_d;
            shift_amt   <= shift_amt_d;
            if (state_q == IDLE && start_valid) begin
                cand_q <= orig;
                tgt_q  <= rotated;
                k_q    <= '0;
            end else if (state_q == SEARCH && !match && !last) begin
                cand_q <= WIDTH'(rotl1(RF_MAX_WIDTH'(cand_q), WIDTH));
                k_q    <= k_q + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rotation_finder.sv
// Randomized scoreboard bench for rotation_finder against a rotate-and-search reference model.
module tb_rotation_finder;

    localparam int unsigned W  = 4;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  orig;
    logic [W-1:0]  rotated;
    logic          done_valid;
    logic          done_ready;
    logic          found;
    logic          dir;
    logic [AW-1:0] shift_amt;

    rotation_finder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .orig       (orig),
        .rotated    (rotated),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .found      (found),
        .dir        (dir),
        .shift_amt  (shift_amt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f;
        int d;
        int a;
        int acc;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int rot_left(input int o, input int k);
        return ((o << k) | (o >> (W - k))) & ((1 << W) - 1);
    endfunction

    // Smallest left rotation wins; tie at W/2 resolves to left.
    function automatic exp_t model(input int o, input int r, input int acc);
        exp_t e;
        bit   hit = 1'b0;
        e.f = 0; e.d = 0; e.a = 0; e.acc = acc; e.lat = W;
        for (int k = 0; k < W; k++) begin
            if (!hit && rot_left(o, k) == r) begin
                hit   = 1'b1;
                e.f   = 1;
                e.lat = k + 1;
                if (k <= W / 2) begin e.d = 0; e.a = k;     end
                else            begin e.d = 1; e.a = W - k; end
            end
        end
        return e;
    endfunction

    // Monitor: pops on each rising done_valid, then checks the result stays stable.
    logic prev_dv = 1'b0;
    int   hf, hd, ha;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done_valid) begin
            if (!prev_dv) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("found", int'(found), e.f);
                    check("dir", int'(dir), e.d);
                    check("shift_amt", int'(shift_amt), e.a);
                    check("latency", cyc - e.acc, e.lat);
                end
                hf = int'(found); hd = int'(dir); ha = int'(shift_amt);
            end else begin
                check("hold_found", int'(found), hf);
                check("hold_dir", int'(dir), hd);
                check("hold_shift_amt", int'(shift_amt), ha);
            end
        end
        prev_dv = done_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int o, input int r, input bit expect_res);
        int n = 0;
        orig        = W'(o);
        rotated     = W'(r);
        start_valid = 1'b1;
        while (!start_ready && n < 20) begin tick(); n++; end
        if (!start_ready) begin
            check("accept_timeout", 0, 1);
            start_valid = 1'b0;
            return;
        end
        tick();
        start_valid = 1'b0;
        if (expect_res) sb.push_back(model(o, r, cyc));
    endtask

    task automatic finish_req(input int hold, input bit toggle);
        int n = 0;
        while (!done_valid && n < 20) begin tick(); n++; end
        if (!done_valid) begin
            check("done_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin
                start_valid = 1'($urandom_range(0, 1));
                orig        = W'($urandom_range(0, 15));
                rotated     = W'($urandom_range(0, 15));
            end
            check("busy_start_ready", int'(start_ready), 0);
            tick();
        end
        start_valid = 1'b0;
        done_ready  = 1'b1;
        tick();
        done_ready = 1'b0;
        check("idle_start_ready", int'(start_ready), 1);
        check("idle_done_valid", int'(done_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int o, r;
        rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0; orig = '0; rotated = '0;
        tick(); tick();
        check("rst_start_ready", int'(start_ready), 1);
        check("rst_done_valid", int'(done_valid), 0);
        check("rst_found", int'(found), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_shift_amt", int'(shift_amt), 0);
        rst = 1'b0;
        tick();

        // Directed scenarios
        issue(4'b1001, 4'b0011, 1'b1); finish_req(0, 1'b0);
        issue(4'b0001, 4'b1000, 1'b1); finish_req(1, 1'b0);
        issue(4'b0011, 4'b1100, 1'b1); finish_req(0, 1'b0);
        issue(4'b1010, 4'b1010, 1'b1); finish_req(0, 1'b0);
        issue(4'b0000, 4'b0000, 1'b1); finish_req(0, 1'b0);
        issue(4'b0001, 4'b0011, 1'b1); finish_req(0, 1'b0);
        issue(4'b0110, 4'b1100, 1'b1); finish_req(5, 1'b1);
        issue(4'b1000, 4'b0100, 1'b1); finish_req(0, 1'b0);

        // Reset two cycles into a k = 3 search; result must never appear
        issue(4'b0001, 4'b1000, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_start_ready", int'(start_ready), 1);
        check("abort_done_valid", int'(done_valid), 0);
        check("abort_found", int'(found), 0);
        check("abort_dir", int'(dir), 0);
        check("abort_shift_amt", int'(shift_amt), 0);
        repeat (8) tick();
        check("abort_no_result", int'(done_valid), 0);

        for (int i = 0; i < 40; i++) begin
            o = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) r = rot_left(o, int'($urandom_range(0, 3)));
            else                           r = int'($urandom_range(0, 15));
            issue(o, r, 1'b1);
            finish_req(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
